// File: rtl/store_rmw_unit.sv
// store_rmw_unit
// Store path between the MEM stage and a word-wide data memory that has no
// byte enables. Full-word stores go straight to a write; halfword and byte
// stores read the word, merge the new lane in, and write the word back.
// Misaligned or unrecognised requests complete immediately without touching
// memory. All memory-side and completion outputs are registered.

module store_rmw_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_type,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] TYPE_SW = 3'b000;
    localparam logic [2:0] TYPE_SH = 3'b001;
    localparam logic [2:0] TYPE_SB = 3'b010;

    state_t            state;

    // Request fields captured at acceptance and used by the merge in RD.
    logic              cap_half;
    logic [1:0]        cap_off;
    logic [15:0]       cap_data;

    logic              accept;
    logic              type_valid;
    logic              misaligned;
    logic [ADDR_W-1:0] word_addr;
    logic [15:0]       lane_data;
    logic [31:0]       merged;

    assign st_ready = (state == IDLE);

    // Decode the incoming request: legality, alignment, word address and lane data.
    always_comb begin
        accept     = st_valid && st_ready;
        type_valid = 1'b0;
        misaligned = 1'b0;
        lane_data  = 16'h0000;
        word_addr  = {st_addr[ADDR_W-1:2], 2'b00};
        case (st_type)
            TYPE_SW: begin
                type_valid = 1'b1;
                misaligned = (st_addr[1:0] != 2'b00);
                lane_data  = st_wdata[15:0];
            end
            TYPE_SH: begin
                type_valid = 1'b1;
                misaligned = st_addr[0];
                lane_data  = st_wdata[15:0];
            end
            TYPE_SB: begin
                type_valid = 1'b1;
                misaligned = 1'b0;
                lane_data  = {8'h00, st_wdata[7:0]};
            end
            default: begin
                type_valid = 1'b0;
                misaligned = 1'b0;
                lane_data  = 16'h0000;
            end
        endcase
    end

    // Overlay the captured halfword or byte onto the word returned by the read.
    always_comb begin
        merged = mem_rdata;
        if (cap_half) begin
            if (cap_off[1]) begin
                merged[31:16] = cap_data;
            end else begin
                merged[15:0] = cap_data;
            end
        end else begin
            case (cap_off)
                2'd0:    merged[7:0]   = cap_data[7:0];
                2'd1:    merged[15:8]  = cap_data[7:0];
                2'd2:    merged[23:16] = cap_data[7:0];
                default: merged[31:24] = cap_data[7:0];
            endcase
        end
    end

    // Control FSM with registered memory and completion outputs; the RD ack
    // edge loads the write values directly so mem_req never drops between RD and WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_half  <= 1'b0;
            cap_off   <= 2'b00;
            cap_data  <= 16'h0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr <= word_addr;
                        cap_half <= (st_type == TYPE_SH);
                        cap_off  <= st_addr[1:0];
                        cap_data <= lane_data;
                        if (!type_valid) begin
                            state   <= RESP;
                            st_done <= 1'b1;
                            st_err  <= 1'b0;
                        end else if (misaligned) begin
                            state   <= RESP;
                            st_done <= 1'b1;
                            st_err  <= 1'b1;
                        end else if (st_type == TYPE_SW) begin
                            state     <= WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= st_wdata;
                        end else begin
                            state   <= RD;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        st_done <= 1'b1;
                        st_err  <= 1'b0;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    st_done <= 1'b0;
                    st_err  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    st_done <= 1'b0;
                    st_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load byte-extract path: takes SW/SH/SB store requests from the pipeline and writes them to a word-wide memory that has no byte enables.
- Full-word stores are written directly.
- Sub-word stores use a read-modify-write sequence: read the word, merge the byte or halfword, write the word back.
- Sits between the MEM stage and the data-memory port.
- Reports completion and misalignment to the pipeline.

Parameters:
ADDR_W, 32, byte-address width; memory port addresses are word-aligned (bits [1:0] forced to 0).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  store request valid
st_ready  output  1  unit can accept a request; equals (state==IDLE)
st_type  input  3  3'b000 SW, 3'b001 SH, 3'b010 SB; any other value is a no-op
st_addr  input  ADDR_W  byte address
st_wdata  input  32  store data; SH uses [15:0], SB uses [7:0]
st_done  output  1  one-cycle completion pulse
st_err  output  1  valid with st_done; 1 = misaligned, no memory access made
mem_req  output  1  memory transaction request; held until mem_ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  word address, {st_addr[ADDR_W-1:2],2'b00}
mem_wdata  output  32  merged write word
mem_rdata  input  32  read data; valid in the mem_ack cycle of a read
mem_ack  input  1  memory completes the current transaction at this clock edge

Behaviour:
- Reset: async on rst_n low, to IDLE. mem_req, mem_we, st_done and st_err = 0; mem_addr and mem_wdata = 0. st_ready = 1 once out of reset.
- Reset mid-operation: the transaction is abandoned. mem_req drops immediately (asynchronously) and no write is issued.
- All mem_* and st_done/st_err outputs are registered; st_ready is decoded from state.
- States are IDLE, RD, WR, RESP.
- Acceptance: st_valid && st_ready at a clock edge. The edge captures type, address, and data (SH: st_wdata[15:0]; SB: st_wdata[7:0]).
- Misalignment check at acceptance:
  - SH requires addr[0]==0.
  - SW requires addr[1:0]==00.
  - SB is never misaligned.
- IDLE transitions on acceptance:
  - Misaligned request -> RESP with st_err=1; no mem_req.
  - Invalid st_type -> RESP with st_err=0; no mem_req.
  - SW -> WR with mem_wdata=st_wdata.
  - SH/SB -> RD.
- RD:
  - mem_req=1, mem_we=0.
  - On mem_ack, latch the merged word into mem_wdata and go to WR. The merge overwrites only the target lane:
    - SH off 0 -> [15:0]; SH off 2 -> [31:16].
    - SB off k -> [8k+7:8k]. All other bits come from mem_rdata.
- WR: mem_req=1, mem_we=1. On mem_ack, go to RESP.
- RESP: st_done=1 for exactly one cycle, then IDLE.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the ack edge. mem_ack when mem_req==0 is ignored.
- Latency from the acceptance edge T, with zero-wait ack (ack high in the first request cycle):
  - SW: done at T+2.
  - SH/SB: done at T+3.
  - Misaligned/no-op: done at T+1.
  - Each wait cycle on mem_ack adds one cycle.
- Between RD and WR, mem_req returns to 0 for no cycle: the RD ack edge loads the WR values directly.
- After the ack edge, mem_req deasserts on the same edge that enters RESP.
- No back-to-back acceptance during RESP: st_ready=0 there, so minimum request spacing is latency+1.
- st_valid while not ready is ignored; the requester holds it.

Test Plan:
- Reset: rst_n=0 mid-RD (mem_req=1) -> mem_req=0 immediately; after release st_ready=1, st_done=0, and the memory word is unchanged.
- SW, addr 0x100, data 0xDEADBEEF, ack always 1 -> no read; one write with mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_we=1; st_done at T+2, st_err=0.
- SB, addr 0x203, data 0x000000AB, memory word 0x11223344 -> read 0x200, then write 0xAB223344; done at T+3.
- SH, addr 0x302, data 0x0000CAFE, memory 0x11223344, ack delayed 2 cycles per transaction -> writes 0xCAFE3344; mem_* stable while waiting; done at T+7.
- Misaligned SH at 0x101 and SW at 0x102 -> no mem_req, st_done+st_err=1 at T+1. SB at 0x101 with memory 0xFFFFFFFF and data 0x00 -> writes 0xFFFF00FF.
- st_type=3'b111 -> st_done at T+1, st_err=0, no mem_req. A new st_valid held during RD/WR/RESP is not accepted until st_ready=1.
